// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes, FSM state encoding and width default
package alu_pkg;

    localparam int ALU_XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } alu_state_e;

    function automatic logic is_shift_op(input logic [3:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_serial.sv
// rtl/alu_shift_serial.sv - bit-serial shifter, one bit position per clock
// Ports: clk_i, rst_ni (async, active-low); load_i captures data_i/shamt_i/dir_right_i/arith_i;
//        next_o is the working value after the shift performed this cycle;
//        done_o flags that this cycle's shift is the last one.
module alu_shift_serial #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic [XLEN-1:0] data_i,
    input  logic [SHW-1:0]  shamt_i,
    input  logic            dir_right_i,
    input  logic            arith_i,
    output logic [XLEN-1:0] next_o,
    output logic            done_o
);

    logic [XLEN-1:0] data_q;
    logic [SHW-1:0]  count_q;
    logic            right_q;
    logic            arith_q;

    // Fill bit for right shifts: sign bit for SRA, zero for SRL.
    always_comb begin
        next_o = data_q;
        if (right_q) begin
            next_o = {(arith_q & data_q[XLEN-1]), data_q[XLEN-1:1]};
        end else begin
            next_o = {data_q[XLEN-2:0], 1'b0};
        end
    end

    // count_q holds the shifts still to do including the current one.
    assign done_o = (count_q == SHW'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            count_q <= '0;
            right_q <= 1'b0;
            arith_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            count_q <= shamt_i;
            right_q <= dir_right_i;
            arith_q <= arith_i;
        end else if (count_q != '0) begin
            data_q  <= next_o;
            count_q <= count_q - SHW'(1);
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - ALU execute stage with valid/ready handshakes (ALU_FAST_SHIFT_EN selects barrel shifter)
// Ports: clk, rst_n (async, active-low), flush (sync abort);
//        in_valid/in_ready with alu_ctrl, op_a, op_b (op_b low bits = shift amount);
//        out_valid/out_ready with registered result and zero flag.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int XLEN = ALU_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int SHW = $clog2(XLEN);

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            rdy_en_q;
    logic            accept;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;

    assign shamt = op_b[SHW-1:0];

    // Single-cycle result. Under the serial build, shift codes fall through to
    // op_a, which is the correct answer only for a zero shift amount; non-zero
    // amounts go through the serial shifter instead.
    always_comb begin
        alu_res = '0;
        unique case (alu_ctrl)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
`ifdef ALU_FAST_SHIFT_EN
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = XLEN'($signed(op_a) >>> shamt);
`else
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  alu_res = op_a;
`endif
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            default:  alu_res = '0;
        endcase
    end

`ifndef ALU_FAST_SHIFT_EN
    logic            sh_load;
    logic            sh_done;
    logic [XLEN-1:0] sh_next;
    logic            is_shift;

    assign is_shift = is_shift_op(alu_ctrl);

    alu_shift_serial #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_shift (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .load_i      (sh_load),
        .data_i      (op_a),
        .shamt_i     (shamt),
        .dir_right_i (alu_ctrl != ALU_SLL),
        .arith_i     (alu_ctrl == ALU_SRA),
        .next_o      (sh_next),
        .done_o      (sh_done)
    );
`endif

    // rdy_en_q keeps in_ready low during reset and until the first clock after release.
    // flush also masks in_ready so an upstream handshake never sees an accept being dropped.
    assign in_ready = rdy_en_q & ~flush &
                      ((state_q == IDLE) | ((state_q == HOLD) & out_ready));
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifndef ALU_FAST_SHIFT_EN
        sh_load  = 1'b0;
`endif
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, HOLD: begin
                    if ((state_q == HOLD) && out_ready) begin
                        state_d = IDLE;
                    end
                    if (accept) begin
`ifndef ALU_FAST_SHIFT_EN
                        if (is_shift && (shamt != '0)) begin
                            state_d = SHIFT;
                            sh_load = 1'b1;
                        end else begin
                            state_d  = HOLD;
                            result_d = alu_res;
                            zero_d   = (alu_res == '0);
                        end
`else
                        state_d  = HOLD;
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
`endif
                    end
                end
                SHIFT: begin
`ifndef ALU_FAST_SHIFT_EN
                    if (sh_done) begin
                        state_d  = HOLD;
                        result_d = sh_next;
                        zero_d   = (sh_next == '0);
                    end
`else
                    state_d = IDLE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            rdy_en_q <= 1'b1;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - self-checking bench for alu_exec_stage with transaction-level reference model
module tb_alu_exec_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_ctrl = 4'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    alu_exec_stage #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int s;
        s = int'(b[4:0]);
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << s;
            4'd6: return a >> s;
            4'd7: return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_extra_lat(input logic [3:0] c, input logic [31:0] b);
`ifdef ALU_FAST_SHIFT_EN
        return 0;
`else
        return (c == 4'd5 || c == 4'd6 || c == 4'd7) ? int'(b[4:0]) : 0;
`endif
    endfunction

    // Transaction model: at most one op in flight; it becomes visible at ready_cyc.
    bit          pending = 0;
    bit          armed = 0;
    int          ready_cyc = 0;
    logic [31:0] m_res = 32'd0;

    initial begin : compare
        bit m_valid;
        bit m_in_ready;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pending = 0;
                armed = 0;
                check("rst_out_valid", {31'd0, out_valid}, 32'd0);
                check("rst_in_ready", {31'd0, in_ready}, 32'd0);
                check("rst_result", result, 32'd0);
                check("rst_zero", {31'd0, zero}, 32'd0);
                continue;
            end
            m_valid = pending && (cyc >= ready_cyc);
            m_in_ready = armed && (!pending || (m_valid && out_ready));
            check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            if (!flush) check("in_ready", {31'd0, in_ready}, {31'd0, m_in_ready});
            if (m_valid) begin
                check("result", result, m_res);
                check("zero", {31'd0, zero}, {31'd0, (m_res == 32'd0)});
            end
            if (flush) begin
                pending = 0;
            end else begin
                if (m_valid && out_ready) pending = 0;
                if (in_valid && m_in_ready) begin
                    pending = 1;
                    m_res = ref_alu(alu_ctrl, op_a, op_b);
                    ready_cyc = cyc + 1 + ref_extra_lat(alu_ctrl, op_b);
                end
            end
            armed = 1;
        end
    end

    task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_zero, input int lat_serial, input int lat_fast);
        int n;
        int k;
        int exp_lat;
`ifdef ALU_FAST_SHIFT_EN
        exp_lat = lat_fast;
`else
        exp_lat = lat_serial;
`endif
        @(posedge clk); #1;
        in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b; out_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        check({name, "_accept"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; op_a = $urandom; op_b = $urandom; alu_ctrl = 4'(($urandom));
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 100);
        check({name, "_latency"}, k, exp_lat);
        check({name, "_result"}, result, exp_res);
        check({name, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
    endtask

    initial begin : stim
        int seen;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_op("add", ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1, 1);
        run_op("sub", ALU_SUB, 32'd3, 32'd3, 32'd0, 1'b1, 1, 1);
        run_op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, 1);
        run_op("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1, 1);
        run_op("code1011", 4'b1011, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b1, 1, 1);
        run_op("sra4", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 5, 1);
        run_op("sll0", ALU_SLL, 32'h0000_1234, 32'd0, 32'h0000_1234, 1'b0, 1, 1);
        run_op("srl31", ALU_SRL, 32'h8000_0000, 32'd31, 32'd1, 1'b0, 32, 1);

        // Back-to-back ADDs: one result per cycle, in_ready never drops.
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; alu_ctrl = ALU_ADD; op_a = 32'(i * 10); op_b = 32'd1;
            @(negedge clk);
            check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
            if (i > 0) begin
                check("b2b_out_valid", {31'd0, out_valid}, 32'd1);
                check("b2b_result", result, 32'((i - 1) * 10 + 1));
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_last_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_last_result", result, 32'd31);

        // Held result under backpressure.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; alu_ctrl = ALU_ADD; op_a = 32'd100; op_b = 32'd23;
        @(posedge clk); #1;
        in_valid = 1'b0; op_a = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_result", result, 32'd123);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("hold_drained", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a long SRL.
        @(posedge clk); #1;
        in_valid = 1'b1; alu_ctrl = ALU_SRL; op_a = 32'hF000_0000; op_b = 32'd20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_no_stale", seen, 0);

        // Flush in the middle of an SLL.
        @(posedge clk); #1;
        in_valid = 1'b1; alu_ctrl = ALU_SLL; op_a = 32'd1; op_b = 32'd20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 flush = 1'b1; in_valid = 1'b1; alu_ctrl = ALU_ADD; op_a = 32'd1; op_b = 32'd1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_no_stale", seen, 0);

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            alu_ctrl  = 4'($urandom_range(0, 15));
            op_a      = $urandom;
            case ($urandom_range(0, 3))
                0: op_b = 32'($urandom_range(0, 3));
                1: op_b = op_a;
                default: op_b = $urandom;
            endcase
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (40) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
